truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequential stimulus-and-capture stage wrapped around a 3-input combinational logic block such as the Wolfram-rule gate modules. Drives the block's `in1`, `in2` and `in3` inputs through all 8 input vectors, waits for the output to settle, and majority-samples the block's `out`. It assembles the observed 8-bit rule number and compares it against an expected rule. It sits directly upstream (stimulus) and downstream (capture) of the gate under test.

## Interface
- `EXPECTED`, default 8'hA7: expected rule number. Bit `[7-idx]` is the output for `idx = {in1,in2,in3}`.
- `SETTLE_CYCLES`, default 16: cycles each vector is held before sampling begins. Legal range is ≥1.
- `SAMPLE_CYCLES`, default 5: cycles of `dut_out` sampling per vector. Must be odd and ≥1.
- `clk` in 1: single clock. One clock only.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begins a sweep. Honoured only in IDLE.
- `abort` in 1: terminates a sweep in progress.
- `dut_out` in 1: output of the gate under test.
- `in1`, `in2`, `in3` out 1 each: registered stimulus to the gate.
- `busy` out 1: high in SETTLE and SAMPLE.
- `done` out 1: one-cycle pulse at the end of a completed sweep.
- `pass` out 1: `observed == EXPECTED`. Valid from `done` onward.
- `observed` out 8: captured rule number, same bit ordering as `EXPECTED`.
- `mismatch` out 8: `observed ^ EXPECTED`. Valid from `done` onward.

## Operation
- States: IDLE → SETTLE → SAMPLE → (SETTLE for next vector | DONE) → IDLE.
- **Reset** (`rst_n` low at a clock edge), all outputs go to 0:
  - `in1`, `in2`, `in3`, `busy`, `done`, `pass`, `observed`, `mismatch` = 0.
  - State = IDLE; vector index = 0; counters = 0.
  - Reset mid-sweep behaves identically: no `done`, results are discarded.
- **IDLE**:
  - `start` = 1: clear `observed`, `mismatch` and `pass`; load vector 0 onto `in1`–`in3`; go to SETTLE.
  - Otherwise hold all results.
- **SETTLE**: hold the vector for `SETTLE_CYCLES` cycles, then go to SAMPLE.
- **SAMPLE**:
  - Count cycles with `dut_out` = 1 over `SAMPLE_CYCLES` cycles.
  - Captured bit = 1 iff count > `SAMPLE_CYCLES`/2 (integer division).
  - Write the bit to `observed[7-idx]`.
  - If 8 vectors are not yet complete, advance the index and drive the next vector in the same edge, then go to SETTLE.
  - After the 8th vector, go to DONE.
- **DONE** (one cycle):
  - `done` = 1; `pass` and `mismatch` are updated.
  - `in1`–`in3` return to 000; next state is IDLE.
- **Abort**: `abort` = 1 in SETTLE or SAMPLE → IDLE next cycle.
  - `in1`–`in3` = 000; `pass` = 0; no `done` pulse.
  - `observed` keeps the bits captured so far; `mismatch` = 0.
  - `abort` in IDLE or DONE is ignored.
- **Simultaneous signals**:
  - `abort` has priority over sweep progression.
  - `start` while busy or in DONE is ignored.
  - `start` and `abort` together in IDLE: start wins, because abort is ignored in IDLE.
- **Counter widths**: each counter is sized `$clog2(max+1)`. The index is 3 bits; wrap to 0 occurs only when returning to IDLE.

## Timing
- All outputs are registered.
- Let `start` be accepted at edge t, and P = `SETTLE_CYCLES` + `SAMPLE_CYCLES`.
- Vector k is driven during cycles t+1+k·P through t+(k+1)·P.
- Sampling covers the last `SAMPLE_CYCLES` cycles of each vector's window.
- `done` is high during cycle t+1+8P, and `busy` falls in the same cycle.
- Earliest next `start` acceptance is at edge t+2+8P.
- Sweep latency with defaults: 1+8·21 = 169 cycles to `done`.

## Configuration
- `SWEEP_GRAY_EN` defined: vectors are applied in Gray order 000, 001, 011, 010, 110, 111, 101, 100, so exactly one input toggles per step. Capture still writes `observed[7-idx]` using the actual vector value.
- `SWEEP_GRAY_EN` undefined: vectors are applied in binary order 000 through 111.
- Timing is identical in both builds.

## Structure
- Shared package `sweep_pkg` contains:
  - The state enum (IDLE, SETTLE, SAMPLE, DONE).
  - `NUM_VECTORS` = 8.
  - A function `vec_of(step)` mapping step to vector, binary or Gray depending on the macro.
- Sub-module `majority_sampler`, which contains:
  - The sample counter and the ones counter.
  - Inputs: `clk`, `rst_n`, `clear`, `en`, `bit_in`.
  - Outputs: `last` (final sample cycle) and `result`.

## Test plan
- **Matching gate**: model of rule 0xA7, `start` pulse → `done` at cycle t+169, `observed` = 8'hA7, `pass` = 1, `mismatch` = 8'h00.
- **Stuck-at-0 output**: `dut_out` tied low → `observed` = 8'h00, `pass` = 0, `mismatch` = 8'hA7.
- **Noise rejection**: glitch `dut_out` for 2 of 5 sample cycles on every vector → `observed` = 8'hA7, `pass` = 1.
- **Abort**: `abort` asserted during vector 3 SAMPLE → IDLE next cycle, stimulus 000, no `done`, `observed[7:5]` = 3'b101, `observed[4:0]` = 0.
- **Reset and ignored start**:
  - `rst_n` low during vector 5 → all outputs 0 next cycle.
  - Subsequent `start` gives a clean full sweep.
  - `start` re-pulsed while busy has no effect.
- **Gray build**: with `SWEEP_GRAY_EN`, check each vector transition has Hamming distance 1 and the same `observed` = 8'hA7.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and the step-to-vector mapping for truth_table_sweeper.
// Defining SWEEP_GRAY_EN switches the sweep order from binary to Gray code.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 8;

  // Maps a sweep step (0..7) to the {in1,in2,in3} vector applied at that step.
  function automatic logic [2:0] vec_of(input logic [2:0] step);
`ifdef SWEEP_GRAY_EN
    return step ^ (step >> 1);
`else
    return step;
`endif
  endfunction

endpackage

// File: rtl/majority_sampler.sv
// Counts high samples over SAMPLE_CYCLES enabled cycles and reports the majority
// decision combinationally on the final sample cycle (flagged by last).
module majority_sampler #(
  parameter int SAMPLE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output logic last,
  output logic result
);

  localparam int CW = $clog2(SAMPLE_CYCLES + 1);

  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] ones_total;

  // The current sample is folded in so the decision is ready on the last cycle.
  assign ones_total = ones_cnt + CW'(bit_in);
  assign last       = en && (sample_cnt == CW'(SAMPLE_CYCLES - 1));
  assign result     = ones_total > CW'(SAMPLE_CYCLES / 2);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
    end else if (en) begin
      if (last) begin
        sample_cnt <= '0;
        ones_cnt   <= '0;
      end else begin
        sample_cnt <= sample_cnt + 1'b1;
        ones_cnt   <= ones_total;
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 8 vectors into a 3-input gate, majority-samples its output and
// compares the captured rule number to EXPECTED. SWEEP_GRAY_EN selects Gray order.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter logic [7:0] EXPECTED      = 8'hA7,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         SAMPLE_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] observed,
  output logic [7:0] mismatch
);

  localparam int         SW        = $clog2(SETTLE_CYCLES + 1);
  localparam logic [2:0] LAST_STEP = 3'(NUM_VECTORS - 1);

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [2:0]    vec_q, vec_d;
  logic          busy_d, done_d, pass_d;
  logic [7:0]    observed_d, mismatch_d;
  logic          smp_clear, smp_en, smp_last, smp_result;

  assign {in1, in2, in3} = vec_q;
  assign smp_en          = (state_q == SAMPLE);

  majority_sampler #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_sampler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (smp_clear),
    .en     (smp_en),
    .bit_in (dut_out),
    .last   (smp_last),
    .result (smp_result)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    settle_d   = settle_q;
    vec_d      = vec_q;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    observed_d = observed;
    mismatch_d = mismatch;
    smp_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          step_d     = '0;
          settle_d   = '0;
          vec_d      = vec_of(3'd0);
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          observed_d = '0;
          mismatch_d = '0;
          smp_clear  = 1'b1;
        end
      end

      SETTLE, SAMPLE: begin
        if (abort) begin
          // Partial capture stays visible; the verdict outputs are cleared.
          state_d    = IDLE;
          step_d     = '0;
          settle_d   = '0;
          vec_d      = '0;
          busy_d     = 1'b0;
          pass_d     = 1'b0;
          mismatch_d = '0;
          smp_clear  = 1'b1;
        end else if (state_q == SETTLE) begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            state_d  = SAMPLE;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end else if (smp_last) begin
          observed_d[3'd7 - vec_q] = smp_result;
          if (step_q == LAST_STEP) begin
            state_d    = DONE;
            vec_d      = '0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            pass_d     = (observed_d == EXPECTED);
            mismatch_d = observed_d ^ EXPECTED;
          end else begin
            state_d = SETTLE;
            step_d  = step_q + 3'd1;
            vec_d   = vec_of(step_q + 3'd1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        step_d  = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      settle_q <= '0;
      vec_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      observed <= '0;
      mismatch <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      observed <= observed_d;
      mismatch <= mismatch_d;
    end
  end

endmodule
